// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths, reset constants and instruction field helpers
package core_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0]    RESET_PC  = 8'h00;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // Instruction field positions, shared with decode
  localparam int FUNCT_HI  = 15;
  localparam int FUNCT_LO  = 11;
  localparam int TARGET_HI = 10;
  localparam int TARGET_LO = 8;
  localparam int A_HI      = 5;
  localparam int A_LO      = 3;
  localparam int B_HI      = 2;
  localparam int B_LO      = 0;
  localparam int IMMED_HI  = 7;
  localparam int IMMED_LO  = 0;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_SKID = 2'd1,
    SRC_RESP = 2'd2
  } fetch_src_e;

  function automatic logic [4:0] get_funct(input logic [INSTR_W-1:0] i_instr);
    return i_instr[FUNCT_HI:FUNCT_LO];
  endfunction

  function automatic logic [2:0] get_target(input logic [INSTR_W-1:0] i_instr);
    return i_instr[TARGET_HI:TARGET_LO];
  endfunction

  function automatic logic [2:0] get_a(input logic [INSTR_W-1:0] i_instr);
    return i_instr[A_HI:A_LO];
  endfunction

  function automatic logic [2:0] get_b(input logic [INSTR_W-1:0] i_instr);
    return i_instr[B_HI:B_LO];
  endfunction

  function automatic logic [7:0] get_immed(input logic [INSTR_W-1:0] i_instr);
    return i_instr[IMMED_HI:IMMED_LO];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] i_val);
    return (i_val == {CNT_W{1'b1}}) ? i_val : i_val + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry holding register for a fetched word and its pc
module fetch_skid_buf #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;

  // Clear wins so a redirect always flushes a word captured the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: pc, imem read issue, skid-buffered presentation to IF/ID
module instr_fetch #(
  parameter int                      PC_W      = core_pkg::PC_W,
  parameter int                      INSTR_W   = core_pkg::INSTR_W,
  parameter logic [PC_W-1:0]         RESET_PC  = core_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0]      NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               jump_taken,
  input  logic [PC_W-1:0]    jump_target,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_o,
  output logic               instr_valid,
  output logic [15:0]        fetch_count
);

  import core_pkg::*;

  logic [PC_W-1:0]    r_pc_q;
  logic [PC_W-1:0]    r_req_pc;
  logic               r_req_pending;
  logic [15:0]        r_fetch_count;

  logic               w_issue;
  logic               w_consume;
  logic               w_skid_load;
  logic               w_skid_clear;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [PC_W-1:0]    w_skid_pc;
  fetch_src_e         w_src;

  // Issue is blocked on stall so at most one read is ever outstanding
  assign w_issue    = rst_n & ~stall & ~jump_taken;
  assign imem_rd_en = w_issue;
  assign imem_addr  = r_pc_q;

  always_comb begin
    w_src = SRC_NONE;
    if (w_skid_valid)       w_src = SRC_SKID;
    else if (r_req_pending) w_src = SRC_RESP;
  end

  // A redirect doubles as the IF/ID clear, so nothing is shown during it
  always_comb begin
    instr       = NOP_INSTR;
    pc_o        = '0;
    instr_valid = 1'b0;
    if (!jump_taken) begin
      unique case (w_src)
        SRC_SKID: begin
          instr       = w_skid_instr;
          pc_o        = w_skid_pc;
          instr_valid = 1'b1;
        end
        SRC_RESP: begin
          instr       = imem_rdata;
          pc_o        = r_req_pc;
          instr_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_consume    = instr_valid & ~stall & ~jump_taken;
  assign w_skid_load  = r_req_pending & ~w_skid_valid & stall & ~jump_taken;
  assign w_skid_clear = jump_taken | (w_consume & (w_src == SRC_SKID));

  fetch_skid_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_instr (imem_rdata),
    .i_pc    (r_req_pc),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_q        <= RESET_PC;
      r_req_pc      <= '0;
      r_req_pending <= 1'b0;
    end else if (jump_taken) begin
      r_pc_q        <= jump_target;
      r_req_pending <= 1'b0;
    end else begin
      // Any response returns the cycle after issue, so pending tracks issue exactly
      r_req_pending <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc_q;
        r_pc_q   <= r_pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_consume) begin
      r_fetch_count <= sat_inc(r_fetch_count);
    end
  end

  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized scoreboard bench for instr_fetch
module tb_instr_fetch;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        jump_taken = 1'b0;
  logic [7:0]  jump_target = 8'h00;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr;
  logic [7:0]  pc_o;
  logic        instr_valid;
  logic [15:0] fetch_count;

  logic [15:0] mem [256];
  int          n_vec = 0;
  int          n_err = 0;

  logic        m_avail;
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;
  logic [23:0] sb_q [$];

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .imem_addr   (imem_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc_o        (pc_o),
    .instr_valid (instr_valid),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid && !stall && !jump_taken) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL consume_unexpected: got pc=%h instr=%h, required no consume", pc_o, instr);
        end else begin
          chk("consume_pc_instr", {8'h00, pc_o, instr}, {8'h00, sb_q.pop_front()});
        end
      end else if (sb_q.size() != 0) begin
        n_vec++;
        n_err++;
        $display("FAIL consume_missed: got no consume, required pc=%h instr=%h",
                 sb_q[0][23:16], sb_q[0][15:0]);
        void'(sb_q.pop_front());
      end
    end
  end

  // Reference: a word for m_pc is available one cycle after an unstalled issue slot
  task automatic step(input logic s, input logic j, input logic [7:0] t);
    logic [7:0] nxt;
    stall = s;
    jump_taken = j;
    jump_target = t;
    #1;
    nxt = m_pc + 8'd1;
    chk("imem_rd_en", {31'h0, imem_rd_en}, {31'h0, (!s && !j)});
    if (!s && !j) chk("imem_addr", {24'h0, imem_addr}, {24'h0, (m_avail ? nxt : m_pc)});
    chk("instr_valid", {31'h0, instr_valid}, {31'h0, (m_avail && !j)});
    if (m_avail && !j) chk("pc_o", {24'h0, pc_o}, {24'h0, m_pc});
    else chk("bubble_out", {8'h00, pc_o, instr}, {8'h00, 8'h00, NOP_INSTR});
    if (j) begin
      m_avail = 1'b0;
      m_pc = t;
    end else if (!m_avail) begin
      if (!s) m_avail = 1'b1;
    end else if (!s) begin
      sb_q.push_back({m_pc, mem[m_pc]});
      m_pc = nxt;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
    chk("fetch_count", {16'h0, fetch_count}, {16'h0, m_cnt});
  endtask

  task automatic run_to(input logic [7:0] p);
    for (int k = 0; k < 300 && !(m_avail && m_pc == p); k++) step(1'b0, 1'b0, 8'h00);
    chk("reach_pc", {23'h0, instr_valid, pc_o}, {23'h0, 1'b1, p});
  endtask

  task automatic do_reset(input bit rand_mem);
    #2;
    rst_n = 1'b0;
    stall = 1'b0;
    jump_taken = 1'b0;
    #1;
    chk("rst_outputs", {6'h0, imem_rd_en, instr_valid, pc_o, instr},
        {6'h0, 1'b0, 1'b0, 8'h00, NOP_INSTR});
    chk("rst_count", {16'h0, fetch_count}, 32'h0);
    sb_q.delete();
    m_avail = 1'b0;
    m_pc = RESET_PC;
    m_cnt = 16'h0000;
    if (rand_mem) for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic       r_s;
  logic       r_j;
  logic [7:0] r_t;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'hA000 + 16'(a);
    do_reset(1'b0);

    repeat (5) step(1'b0, 1'b0, 8'h00);
    run_to(8'h04);
    repeat (3) begin
      step(1'b1, 1'b0, 8'h00);
      chk("stall_hold", {7'h0, instr_valid, pc_o, instr}, {7'h0, 1'b1, 8'h04, mem[8'h04]});
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    run_to(8'h07);
    step(1'b0, 1'b1, 8'h40);
    step(1'b0, 1'b0, 8'h00);
    run_to(8'h40);
    chk("jump_word", {16'h0, instr}, {16'h0, mem[8'h40]});
    step(1'b0, 1'b0, 8'h00);

    step(1'b0, 1'b1, 8'h08);
    run_to(8'h09);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h20);
    step(1'b0, 1'b0, 8'h00);
    run_to(8'h20);
    step(1'b0, 1'b0, 8'h00);

    step(1'b0, 1'b1, 8'hFE);
    run_to(8'h01);
    step(1'b0, 1'b0, 8'h00);

    force dut.r_fetch_count = 16'hFFFE;
    #1;
    release dut.r_fetch_count;
    m_cnt = 16'hFFFE;
    repeat (4) step(1'b0, 1'b0, 8'h00);
    chk("count_saturated", {16'h0, fetch_count}, 32'h0000FFFF);

    run_to(8'h10);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    do_reset(1'b1);
    step(1'b0, 1'b0, 8'h00);
    run_to(8'h02);

    for (int i = 0; i < 500; i++) begin
      r_s = ($urandom_range(0, 9) < 3);
      r_j = ($urandom_range(0, 19) == 0);
      r_t = 8'($urandom);
      step(r_s, r_j, r_t);
    end
    step(1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage of the 8-bit pipelined core. Directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues reads to a synchronous instruction memory (1-cycle read latency).
- Presents each fetched 16-bit instruction and its PC to IF/ID.
- Honours the hazard-unit stall and the jump redirect, using a 1-entry skid buffer so that no fetched word is lost or duplicated.

Parameters:
- PC_W, 8: program counter and instruction-memory address width.
- INSTR_W, 16: instruction width.
- RESET_PC, 8'h00: first fetch address after reset.
- NOP_INSTR, 16'h0000: word driven on instr when nothing valid is presented (matches IF/ID clear value).

Ports:
- clk  input  1  single clock; rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  from hazard unit, same signal as IF/ID stall; 1 = IF/ID will not capture this cycle.
- jump_taken  input  1  redirect request; same signal as the IF/ID clear.
- jump_target  input  PC_W  redirect address, valid when jump_taken=1.
- imem_addr  output  PC_W  instruction-memory read address.
- imem_rd_en  output  1  read strobe; data returns on imem_rdata the following cycle.
- imem_rdata  input  INSTR_W  read data, valid one cycle after an accepted imem_rd_en.
- instr  output  INSTR_W  instruction presented to IF/ID.
- pc_o  output  PC_W  address of the presented instruction.
- instr_valid  output  1  presented instruction is real (not a bubble).
- fetch_count  output  16  count of instructions consumed by IF/ID; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync-safe deassert use):
  - pc_q=RESET_PC; req_pending=0; skid_valid=0; fetch_count=0.
  - instr=NOP_INSTR, instr_valid=0, pc_o=0, imem_rd_en=0 while rst_n=0.
  - A reset mid-fetch discards any in-flight response.
- State:
  - pc_q: next fetch address.
  - req_pending / req_pc: one read in flight.
  - skid_valid / skid_instr / skid_pc: one held word.
- Issue:
  - imem_addr=pc_q.
  - imem_rd_en = rst_n & ~stall & ~jump_taken.
  - On issue: req_pending<=1, req_pc<=pc_q, pc_q<=pc_q+1. PC wraps 8'hFF -> 8'h00.
- Presentation (combinational):
  - If skid_valid: present skid_instr / skid_pc, instr_valid=1.
  - Else if req_pending: present imem_rdata / req_pc, instr_valid=1.
  - Else: NOP_INSTR, pc_o=0, instr_valid=0.
- Consume = instr_valid & ~stall & ~jump_taken.
  - On consume: skid_valid<=0 if the source was the skid; fetch_count increments.
- Stall capture: if req_pending & ~skid_valid & stall & ~jump_taken, then skid_valid<=1 and the skid captures imem_rdata / req_pc. req_pending clears the cycle after any response returns.
- Invariants:
  - Issue only occurs when ~stall, so at most one read is in flight and the skid never overflows.
  - skid_valid and a new response never coexist un-consumed.
- Throughput and latency:
  - 1 instruction/cycle in steady state.
  - First valid instr appears 1 cycle after the first issue, i.e. cycle 2 after reset release.
  - Stall release: the skid word is consumed and the next address is issued in the same cycle, so no bubble.
- Jump (priority over stall):
  - pc_q<=jump_target; req_pending<=0; skid_valid<=0; no issue this cycle.
  - Next cycle issues jump_target; its instruction is valid the cycle after that.
  - The redirect therefore costs 2 bubble cycles at the IF output (instr_valid=0, NOP_INSTR).
  - A jump_taken held for multiple cycles re-targets each cycle; the last target wins.
- Simultaneous stall and jump: treated as jump.
- Stall with no valid word: no state change except that issue is blocked.
- fetch_count: 16-bit, saturating, never wraps.

Decomposition:
- Shared package core_pkg: PC_W, INSTR_W, NOP_INSTR, RESET_PC.
  - ID-side field slices (funct [15:11], target [10:8], A [5:3], B [2:0], immed [7:0]) live there too, for reuse by decode.
- One sub-module: fetch_skid_buf, a 1-entry holding register (load/clear/valid, data + pc) with async active-low reset.

Test Plan:
- Reset release, stall=0, memory holds word k = 16'hA000+k: imem_addr 0,1,2,... on consecutive cycles; instr_valid=1 from cycle 2; pc_o/instr = 0/A000, 1/A001, ...; fetch_count=3 after 3 valid cycles.
- Stall asserted for 3 cycles while pc_o=4 is presented: instr=A004 and pc_o=4 held, imem_rd_en=0 throughout. On release, A004 is consumed and addr 5 issued in the same cycle. Next cycle A005: no duplicate, no gap.
- jump_taken with jump_target=8'h40 while a read of addr 7 is in flight: A007 never reaches instr_valid=1. Two bubble cycles follow, then pc_o=8'h40 / instr=A040.
- jump_taken and stall both asserted with skid holding pc 9: skid is flushed and the redirect proceeds as in the previous scenario; pc 9 is never presented.
- Run from pc 8'hFE with no stall: pc_o sequence FE, FF, 00, 01. Also verify fetch_count saturates at FFFF when preloaded via force to FFFE.
- Assert rst_n low mid-stream with the skid full: outputs go to reset values immediately (asynchronous). After release, fetch restarts at RESET_PC with no stale word presented.
